// File: rtl/alu_seq_pkg.sv
// Shared types and helpers for the sequential ALU with BCD output stage.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_BCD  = 2'b10,
        S_DONE = 2'b11
    } state_e;

    // One double-dabble step per result bit.
    function automatic int bcd_cycles(input int width);
        return 2 * width;
    endfunction

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] v;
        v = 64'd1;
        for (int i = 0; i < n; i++) v = v * 64'd10;
        return v;
    endfunction

endpackage

// File: rtl/bcd_dd.sv
// Serial double-dabble converter: start loads the binary value, one shift-add-3
// step per cycle, bcd_o/ovf_o updated on the final step and held until cleared.
module bcd_dd
    import alu_seq_pkg::*;
#(
    parameter int BIN_W = 10,
    parameter int NDIG  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear_i,
    input  logic                start_i,
    input  logic [BIN_W-1:0]    bin_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [4*NDIG-1:0]   bcd_o,
    output logic                ovf_o
);
    localparam int          BW    = 4 * NDIG;
    localparam int          CW    = $clog2(BIN_W + 1);
    localparam logic [63:0] MAXV  = pow10(NDIG) - 64'd1;
    localparam logic [BW-1:0] NINES = {NDIG{4'h9}};

    logic [BIN_W-1:0] sh_q, sh_d;
    logic [BW-1:0]    dig_q, dig_d, adj, dig_nx;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d, pend_q, pend_d, ovf_q, ovf_d;
    logic [BW-1:0]    bcd_q, bcd_d;

    assign done_o = busy_q && (cnt_q == CW'(1));
    assign busy_o = busy_q;
    assign bcd_o  = bcd_q;
    assign ovf_o  = ovf_q;

    always_comb begin
        adj = dig_q;
        for (int i = 0; i < NDIG; i++)
            if (dig_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = dig_q[4*i +: 4] + 4'd3;
        dig_nx = {adj[BW-2:0], sh_q[BIN_W-1]};

        sh_d   = sh_q;
        dig_d  = dig_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        pend_d = pend_q;
        bcd_d  = bcd_q;
        ovf_d  = ovf_q;
        if (clear_i) begin
            bcd_d = '0;
            ovf_d = 1'b0;
        end
        if (start_i) begin
            sh_d   = bin_i;
            dig_d  = '0;
            cnt_d  = CW'(BIN_W);
            busy_d = 1'b1;
            pend_d = 64'(bin_i) > MAXV;
        end else if (busy_q) begin
            sh_d  = sh_q << 1;
            dig_d = dig_nx;
            cnt_d = cnt_q - CW'(1);
            if (done_o) begin
                busy_d = 1'b0;
                bcd_d  = pend_q ? NINES : dig_nx;
                ovf_d  = pend_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_q   <= '0;
            dig_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            pend_q <= 1'b0;
            bcd_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            dig_q  <= dig_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            pend_q <= pend_d;
            bcd_q  <= bcd_d;
            ovf_q  <= ovf_d;
        end
    end

endmodule

// File: rtl/alu_seq_bcd.sv
// Multi-cycle add/sub/mul/div ALU with valid/ready handshakes and optional BCD stage.
// Define ALU_SEQ_BCD_EN to include the double-dabble converter and its BCD state.
module alu_seq_bcd
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int NDIG  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     num1,
    input  logic [WIDTH-1:0]     num2,
    input  logic [1:0]           operation,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic [4*NDIG-1:0]    bcd_out,
    output logic                 neg,
    output logic                 div_err,
    output logic                 bcd_ovf
);
    localparam int RW = 2 * WIDTH;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [RW-1:0]    opa_q, opa_d, prod_q, prod_d, result_q, result_d;
    logic [WIDTH-1:0] opb_q, opb_d, rem_q, rem_d, cnt_q, cnt_d;
    logic             neg_q, neg_d, derr_q, derr_d;
    logic             accept, calc_last;
    logic [RW-1:0]    sum_ext, diff_ext, prod_nx;
    logic [WIDTH:0]   trial, trial_sub;
    logic             ge;
    logic [WIDTH-1:0] rem_nx, quo_nx;

    assign accept    = (state_q == S_IDLE) && in_valid;
    assign calc_last = (op_q == OP_ADD) || (op_q == OP_SUB) || (cnt_q == WIDTH'(WIDTH - 1));

    // opa_q holds the multiplicand (shifting left) or the dividend/quotient shifter.
    assign sum_ext   = opa_q + RW'(opb_q);
    assign diff_ext  = opa_q - RW'(opb_q);
    assign prod_nx   = prod_q + (opb_q[0] ? opa_q : '0);
    assign trial     = {rem_q, opa_q[WIDTH-1]};
    assign trial_sub = trial - {1'b0, opb_q};
    assign ge        = trial >= {1'b0, opb_q};
    assign rem_nx    = ge ? trial_sub[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_nx    = {opa_q[WIDTH-2:0], ge};

`ifdef ALU_SEQ_BCD_EN
    logic          cvt_start, cvt_busy, cvt_done;
    logic [RW-1:0] cvt_val;

    always_comb begin
        case (op_q)
            OP_ADD:  cvt_val = sum_ext;
            OP_SUB:  cvt_val = (opa_q < RW'(opb_q)) ? (RW'(opb_q) - opa_q) : diff_ext;
            OP_MUL:  cvt_val = prod_nx;
            default: cvt_val = (opb_q == '0) ? '0 : RW'(quo_nx);
        endcase
    end

    assign cvt_start = (state_q == S_CALC) && calc_last;

    bcd_dd #(
        .BIN_W (bcd_cycles(WIDTH)),
        .NDIG  (NDIG)
    ) u_bcd (
        .clk     (clk),
        .reset   (reset),
        .clear_i (accept),
        .start_i (cvt_start),
        .bin_i   (cvt_val),
        .busy_o  (cvt_busy),
        .done_o  (cvt_done),
        .bcd_o   (bcd_out),
        .ovf_o   (bcd_ovf)
    );
`else
    assign bcd_out = '0;
    assign bcd_ovf = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        rem_d    = rem_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        neg_d    = neg_q;
        derr_d   = derr_q;
        case (state_q)
            S_IDLE: if (accept) begin
                state_d = S_CALC;
                op_d    = op_e'(operation);
                opa_d   = RW'(num1);
                opb_d   = num2;
                rem_d   = '0;
                prod_d  = '0;
                cnt_d   = '0;
                neg_d   = 1'b0;
                derr_d  = 1'b0;
            end
            S_CALC: begin
                cnt_d = cnt_q + WIDTH'(1);
                case (op_q)
                    OP_MUL: begin
                        prod_d = prod_nx;
                        opa_d  = opa_q << 1;
                        opb_d  = opb_q >> 1;
                    end
                    OP_DIV: begin
                        rem_d = rem_nx;
                        opa_d = RW'(quo_nx);
                    end
                    default: ;
                endcase
                if (calc_last) begin
                    case (op_q)
                        OP_ADD: result_d = sum_ext;
                        OP_SUB: begin
                            result_d = diff_ext;
                            neg_d    = opa_q < RW'(opb_q);
                        end
                        OP_MUL: result_d = prod_nx;
                        default: begin
                            derr_d   = (opb_q == '0);
                            result_d = (opb_q == '0) ? '1 : {rem_nx, quo_nx};
                        end
                    endcase
`ifdef ALU_SEQ_BCD_EN
                    state_d = S_BCD;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef ALU_SEQ_BCD_EN
            // Fall out of BCD if the converter is ever idle here, so the FSM cannot stall.
            S_BCD: if (cvt_done || !cvt_busy) state_d = S_DONE;
`endif
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= OP_ADD;
            opa_q    <= '0;
            opb_q    <= '0;
            rem_q    <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            neg_q    <= 1'b0;
            derr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            rem_q    <= rem_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            neg_q    <= neg_d;
            derr_q   <= derr_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign neg       = neg_q;
    assign div_err   = derr_q;

endmodule
